// File: rtl/reg_16b_shiftout_if.sv
// Load and serial handshake bundle for reg_16b_shiftout.
// The master drives the word and consumer readiness, and the slave reports status.
interface reg_16b_shiftout_if;
  logic [15:0] inData;
  logic        loadValid;
  logic        loadReady;
  logic        serReady;
  logic        serValid;
  logic        serOut;
  logic [3:0]  bitIdx;
  logic        busy;
  logic        done;

  modport master (
    output inData, loadValid, serReady,
    input  loadReady, serValid, serOut, bitIdx, busy, done
  );

  modport slave (
    input  inData, loadValid, serReady,
    output loadReady, serValid, serOut, bitIdx, busy, done
  );
endinterface

// File: rtl/reg_16b_shiftout.sv
// Parallel-load, bit-serial readout register: accepts one 16-bit word, streams it out
// one bit per accepted cycle, then pulses done for one cycle before returning to idle.
module reg_16b_shiftout #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  reg_16b_shiftout_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  count;
  logic        load_ready;
  logic        ser_valid;
  logic        busy_q;
  logic        done_q;

  logic [15:0] sr;
  logic [15:0] sr_d;
  logic        sr_en;

  always_comb begin
    sr_d  = sr;
    sr_en = 1'b0;
    case (state)
      IDLE: begin
        if (bus.loadValid) begin
          sr_d  = bus.inData;
          sr_en = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.serReady) begin
          sr_en = 1'b1;
          if (MSB_FIRST) sr_d = {sr[14:0], 1'b0};
          else           sr_d = {1'b0, sr[15:1]};
        end
      end
      default: begin
        sr_d  = sr;
        sr_en = 1'b0;
      end
    endcase
  end

  // One enabled flop per bit; reset clears the word regardless of the enable.
  for (genvar i = 0; i < 16; i++) begin : g_sr
    always_ff @(posedge clk) begin
      if (rst)        sr[i] <= 1'b0;
      else if (sr_en) sr[i] <= sr_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 4'd0;
      load_ready <= 1'b1;
      ser_valid  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.loadValid) begin
            state      <= SHIFT;
            count      <= 4'd0;
            load_ready <= 1'b0;
            ser_valid  <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.serReady) begin
            if (count == 4'd15) begin
              state     <= DONE;
              count     <= 4'd0;
              ser_valid <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              count <= count + 4'd1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          load_ready <= 1'b1;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          count      <= 4'd0;
          load_ready <= 1'b1;
          ser_valid  <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // serOut is forced low outside SHIFT so idle/done cycles never leak stale word bits.
  assign bus.serOut    = ser_valid & (MSB_FIRST ? sr[15] : sr[0]);
  assign bus.serValid  = ser_valid;
  assign bus.loadReady = load_ready;
  assign bus.bitIdx    = count;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_reg_16b_shiftout.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share one stimulus stream
// and are checked against a word/bit-count reference model.
module tb_reg_16b_shiftout;

  logic clk;
  logic rst;

  reg_16b_shiftout_if bus_m ();
  reg_16b_shiftout_if bus_l ();

  assign bus_l.inData    = bus_m.inData;
  assign bus_l.loadValid = bus_m.loadValid;
  assign bus_l.serReady  = bus_m.serReady;

  reg_16b_shiftout #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
  reg_16b_shiftout #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       load_ready;
    logic       ser_valid;
    logic       busy;
    logic       done;
    logic       out_m;
    logic       out_l;
    logic [3:0] idx;
  } cyc_t;

  typedef struct {
    logic       out_m;
    logic       out_l;
    logic [3:0] idx;
  } bit_t;

  cyc_t cyc_q[$];
  bit_t bit_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: the word in flight, how many of its bits remain, and a done flag.
  logic [15:0] mword = 16'h0000;
  int          remaining = 0;
  bit          in_done = 1'b0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic lv, input logic [15:0] d, input logic sr);
    cyc_t c;
    bit_t b;
    bit   idle;
    rst             = r;
    bus_m.loadValid = lv;
    bus_m.inData    = d;
    bus_m.serReady  = sr;

    idle         = (remaining == 0) && !in_done;
    c.load_ready = idle;
    c.ser_valid  = (remaining > 0);
    c.busy       = !idle;
    c.done       = in_done;
    c.idx        = (remaining > 0) ? 4'(16 - remaining) : 4'd0;
    c.out_m      = (remaining > 0) ? mword[remaining - 1] : 1'b0;
    c.out_l      = (remaining > 0) ? mword[16 - remaining] : 1'b0;
    cyc_q.push_back(c);

    if (remaining > 0 && sr) begin
      b.out_m = c.out_m;
      b.out_l = c.out_l;
      b.idx   = c.idx;
      bit_q.push_back(b);
    end

    if (r) begin
      remaining = 0;
      in_done   = 1'b0;
    end else if (idle) begin
      if (lv) begin
        mword     = d;
        remaining = 16;
      end
    end else if (remaining > 0) begin
      if (sr) begin
        remaining--;
        if (remaining == 0) in_done = 1'b1;
      end
    end else begin
      in_done = 1'b0;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic runWord(input logic [15:0] w, input int ncycles);
    applyStimulus(1'b0, 1'b1, w, 1'b1);
    for (int k = 0; k < ncycles; k++) applyStimulus(1'b0, 1'b0, 16'($urandom), 1'b1);
  endtask

  always @(negedge clk) begin
    cyc_t c;
    bit_t b;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      checkOutput("m_loadReady", 16'(bus_m.loadReady), 16'(c.load_ready));
      checkOutput("l_loadReady", 16'(bus_l.loadReady), 16'(c.load_ready));
      checkOutput("m_serValid",  16'(bus_m.serValid),  16'(c.ser_valid));
      checkOutput("l_serValid",  16'(bus_l.serValid),  16'(c.ser_valid));
      checkOutput("m_busy",      16'(bus_m.busy),      16'(c.busy));
      checkOutput("l_busy",      16'(bus_l.busy),      16'(c.busy));
      checkOutput("m_done",      16'(bus_m.done),      16'(c.done));
      checkOutput("l_done",      16'(bus_l.done),      16'(c.done));
      checkOutput("m_bitIdx",    16'(bus_m.bitIdx),    16'(c.idx));
      checkOutput("l_bitIdx",    16'(bus_l.bitIdx),    16'(c.idx));
      checkOutput("m_serOut",    16'(bus_m.serOut),    16'(c.out_m));
      checkOutput("l_serOut",    16'(bus_l.serOut),    16'(c.out_l));
    end
    if (bus_m.serValid === 1'b1 && bus_m.serReady === 1'b1) begin
      if (bit_q.size() == 0) begin
        checkOutput("unexpected_bit", 16'd1, 16'd0);
      end else begin
        b = bit_q.pop_front();
        checkOutput("m_bit",     16'(bus_m.serOut), 16'(b.out_m));
        checkOutput("l_bit",     16'(bus_l.serOut), 16'(b.out_l));
        checkOutput("m_bit_idx", 16'(bus_m.bitIdx), 16'(b.idx));
        checkOutput("l_bit_idx", 16'(bus_l.bitIdx), 16'(b.idx));
      end
    end
  end

  initial begin
    rst             = 1'b1;
    bus_m.loadValid = 1'b0;
    bus_m.inData    = 16'h0000;
    bus_m.serReady  = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset with random inputs");
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 1'($urandom), 16'($urandom), 1'($urandom));
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);

    $display("[TB] full-speed word 0xA5C3");
    runWord(16'hA5C3, 18);

    $display("[TB] single set bit 0x0001");
    runWord(16'h0001, 18);

    $display("[TB] backpressure on 0x8000");
    applyStimulus(1'b0, 1'b1, 16'h8000, 1'b0);
    for (int k = 0; k < 70; k++) applyStimulus(1'b0, 1'b0, 16'h0000, (k % 4 == 0) || (k % 4 == 3));

    $display("[TB] loads ignored while busy");
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);
    for (int k = 0; k < 18; k++) applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1);

    $display("[TB] back-to-back loads");
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b1, 16'h1111 + 16'(k), 1'b1);
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);

    $display("[TB] reset after seven bits");
    runWord(16'h1234, 7);
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b1);
    runWord(16'h00FF, 19);

    $display("[TB] reset on the final accepted bit");
    runWord(16'hFFFF, 15);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);

    $display("[TB] random traffic");
    for (int k = 0; k < 1500; k++)
      applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));

    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);

    @(negedge clk);
    #1;
    checkOutput("bit_queue_drained", 16'(bit_q.size()), 16'd0);
    checkOutput("cycle_queue_drained", 16'(cyc_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_16b_shiftout.md
# reg_16b_shiftout

Parallel-load, serial-readout companion to the 16-bit write-enabled storage register. It accepts one 16-bit word over a valid/ready load handshake, then drives the word out one bit per accepted cycle over a valid/ready serial handshake, and pulses `done` after the last bit. It sits between a register-file or pipeline data output and any bit-serial consumer, such as a debug/trace port or a serial link.

## Interface
- `MSB_FIRST`, default 1. 1 means bit 15 is sent first; 0 means bit 0 is sent first.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inData` in 16: word to serialize; sampled only on load acceptance.
- `loadValid` in 1: producer has a word on `inData`.
- `loadReady` out 1: block can accept a word (IDLE only).
- `serReady` in 1: consumer accepts the current serial bit this cycle.
- `serValid` out 1: `serOut` holds a valid bit.
- `serOut` out 1: current serial bit; 0 whenever `serValid`=0.
- `bitIdx` out 4: number of bits already accepted for the current word (0..15).
- `busy` out 1: high in SHIFT or DONE.
- `done` out 1: one-cycle pulse after the 16th bit is accepted.

## Operation
- Storage is a 16-bit shift register built from `dff` cells, a 4-bit bit counter, and a 2-bit state register.
- Each state flop holds its value unless its state-specific enable is true.
- States are IDLE, SHIFT and DONE. All outputs are decoded from registered state only; there are no input-to-output combinational paths except through the handshakes.
- **IDLE**
  - Outputs: `loadReady`=1, `serValid`=0, `busy`=0, `done`=0.
  - On `loadValid`=1: load `inData` into the shift register, clear the counter, go to SHIFT.
- **SHIFT**
  - Outputs: `serValid`=1, `busy`=1, `loadReady`=0.
  - `serOut` = sr[15] when `MSB_FIRST`=1, otherwise sr[0].
  - On `serReady`=1 (bit accepted): shift toward the output end, zero-filling, and increment the counter.
  - If the accepted bit is the 16th (counter=15), go to DONE and wrap the counter to 0.
  - On `serReady`=0: hold the shift register, counter and `serOut` stable. `serValid` never drops mid-word.
- **DONE**
  - Outputs: `done`=1, `busy`=1, `serValid`=0, `loadReady`=0.
  - Unconditionally go to IDLE on the next edge.
- **Flow-control rules**
  - `loadValid` is ignored outside IDLE; no word is queued.
  - `inData` changes outside load acceptance have no effect.
- **Reset values** (from the first edge with `rst`=1)
  - State: IDLE. Shift register: 0x0000. Counter: 0.
  - Outputs: `loadReady`=1, `serValid`=0, `serOut`=0, `bitIdx`=0, `busy`=0, `done`=0.
- **Boundary conditions**
  - `rst` asserted mid-word: the word is discarded and `done` is not pulsed.
  - `rst` together with `loadValid`: reset wins; no load.
  - `rst` together with the final `serReady`: reset wins; no DONE.
  - Undefined state encoding: the next state is IDLE.

## Timing
- Load accepted at edge N: first bit is valid in cycle N+1.
- With `serReady` held at 1: bits occupy cycles N+1..N+16, `done` is high in cycle N+17, and `loadReady` is high again in cycle N+18.
- Minimum word period is 18 cycles. Each `serReady`=0 cycle in SHIFT adds exactly one cycle.
- `bitIdx` equals the number of bits accepted so far. It reads 0 on the first bit and 15 on the last.
- `done` is high for exactly one cycle per completed word.

## Test plan
- **Reset:** assert `rst` with random inputs → next cycle `loadReady`=1, `serValid`=0, `serOut`=0, `done`=0, `bitIdx`=0.
- **MSB-first word:** `MSB_FIRST`=1, load 0xA5C3, `serReady`=1 → `serOut` sequence 1010010111000011 in cycles N+1..N+16; `done` high only at N+17; `loadReady` high at N+18.
- **LSB-first word:** `MSB_FIRST`=0, load 0x0001 → `serOut` 1 in cycle N+1 followed by 15 zeros; `bitIdx` runs 0..15.
- **Backpressure:** load 0x8000 and toggle `serReady` 1,0,0,1… → `serOut` and `bitIdx` hold during stalls; `serValid` stays 1; `done` arrives exactly 16 accepted bits later.
- **Load ignored while busy:** pulse `loadValid` with 0xFFFF during SHIFT of 0x0000 → output is all zeros and `loadReady` stays 0; back-to-back loads: the second word starts only at N+18.
- **Reset mid-word:** assert `rst` after 7 bits of 0x1234 → IDLE on the next edge, no `done` pulse; a following load of 0x00FF serializes correctly from bit 0 of the count.
